// File: rtl/b2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and the per-digit add-3 correction.
package b2bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [DIGIT_W-1:0] add3_digit(input logic [DIGIT_W-1:0] d);
        return (d > 4'd4) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble step: add-3 correction on every digit,
// then a one-bit left shift with a serial bit entering digit 0.
module bcd_dabble_step
    import b2bcd_pkg::*;
#(
    parameter int DIGIT = 5
) (
    input  logic [DIGIT*DIGIT_W-1:0] bcd,
    input  logic                     serial,
    output logic [DIGIT*DIGIT_W-1:0] next_bcd,
    output logic                     carry
);

    localparam int BCD_W = DIGIT * DIGIT_W;

    logic [BCD_W-1:0] adjusted;

    always_comb begin
        // NOTE: default the whole vector first so no path through the loop leaves bits unassigned (no latch).
        adjusted = '0;
        for (int d = 0; d < DIGIT; d++) begin
            adjusted[d*DIGIT_W +: DIGIT_W] = add3_digit(bcd[d*DIGIT_W +: DIGIT_W]);
        end
    end

    // The top digit's bit 3 falls off the register and becomes the overflow contribution.
    assign next_bcd = {adjusted[BCD_W-2:0], serial};
    assign carry    = adjusted[BCD_W-1];

endmodule

// File: rtl/b2bcd_seq.sv
// Sequential binary-to-BCD converter: BPC double-dabble steps per clock,
// optional two's-complement input, sticky overflow, valid/ready on both sides.
module b2bcd_seq
    import b2bcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 5,
    parameter int BPC   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_signed,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sign,
    output logic [DIGIT*DIGIT_W-1:0] out_bcd,
    output logic                     out_overflow
);

    localparam int BCD_W = DIGIT * DIGIT_W;
    localparam int STEPS = WIDTH / BPC;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    state_t             state, state_next;
    logic [BCD_W-1:0]   bcd_q;
    logic [WIDTH-1:0]   mag_q;
    logic               sign_q;
    logic               ovf_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept;
    logic               neg;
    logic [WIDTH-1:0]   neg_mag;

    assign accept  = in_valid && in_ready;
    assign neg     = in_signed && in_data[WIDTH-1];
    assign neg_mag = ~in_data + WIDTH'(1);

    // BPC chained steps; index 0 is the registered state, index BPC the next state.
    logic [BCD_W-1:0] bcd_chain [BPC+1];
    logic [WIDTH-1:0] mag_chain [BPC+1];
    logic             ovf_chain [BPC+1];

    assign bcd_chain[0] = bcd_q;
    assign mag_chain[0] = mag_q;
    assign ovf_chain[0] = ovf_q;

    for (genvar k = 0; k < BPC; k++) begin : g_step
        logic carry;

        bcd_dabble_step #(.DIGIT(DIGIT)) u_step (
            .bcd      (bcd_chain[k]),
            .serial   (mag_chain[k][WIDTH-1]),
            .next_bcd (bcd_chain[k+1]),
            .carry    (carry)
        );

        assign mag_chain[k+1] = mag_chain[k] << 1;
        assign ovf_chain[k+1] = ovf_chain[k] | carry;
    end

    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CONV;
            CONV:    if (cnt_q == '0) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q  <= '0;
            mag_q  <= '0;
            sign_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_q <= neg;
                        mag_q  <= neg ? neg_mag : in_data;
                        bcd_q  <= '0;
                        ovf_q  <= 1'b0;
                        cnt_q  <= CNT_W'(STEPS - 1);
                    end
                end
                CONV: begin
                    bcd_q <= bcd_chain[BPC];
                    mag_q <= mag_chain[BPC];
                    ovf_q <= ovf_chain[BPC];
                    if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = (state == IDLE);
    assign out_valid    = (state == DONE);
    assign out_sign     = sign_q;
    assign out_bcd      = bcd_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_b2bcd_seq.sv
// Directed self-checking bench for b2bcd_seq over three parameter sets:
// (16,5,1), (16,4,1) for overflow/truncation, and (16,5,4) for multi-bit steps.
module tb_b2bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_signed = 1'b0;
    logic [15:0] in_data = '0;
    int          sel = 0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    logic        a_in_ready, a_out_valid, a_out_sign, a_out_overflow;
    logic [19:0] a_out_bcd;
    logic        b_in_ready, b_out_valid, b_out_sign, b_out_overflow;
    logic [15:0] b_out_bcd;
    logic        c_in_ready, c_out_valid, c_out_sign, c_out_overflow;
    logic [19:0] c_out_bcd;

    b2bcd_seq #(.WIDTH(16), .DIGIT(5), .BPC(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 0), .in_ready(a_in_ready),
        .in_signed(in_signed), .in_data(in_data), .out_valid(a_out_valid),
        .out_ready(out_ready && sel == 0), .out_sign(a_out_sign), .out_bcd(a_out_bcd),
        .out_overflow(a_out_overflow)
    );

    b2bcd_seq #(.WIDTH(16), .DIGIT(4), .BPC(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(b_in_ready),
        .in_signed(in_signed), .in_data(in_data), .out_valid(b_out_valid),
        .out_ready(out_ready && sel == 1), .out_sign(b_out_sign), .out_bcd(b_out_bcd),
        .out_overflow(b_out_overflow)
    );

    b2bcd_seq #(.WIDTH(16), .DIGIT(5), .BPC(4)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2), .in_ready(c_in_ready),
        .in_signed(in_signed), .in_data(in_data), .out_valid(c_out_valid),
        .out_ready(out_ready && sel == 2), .out_sign(c_out_sign), .out_bcd(c_out_bcd),
        .out_overflow(c_out_overflow)
    );

    // View of whichever instance is currently selected.
    logic        m_in_ready, m_out_valid, m_out_sign, m_ovf;
    logic [19:0] m_out_bcd;

    always_comb begin
        m_in_ready  = a_in_ready;
        m_out_valid = a_out_valid;
        m_out_sign  = a_out_sign;
        m_out_bcd   = a_out_bcd;
        m_ovf       = a_out_overflow;
        if (sel == 1) begin
            m_in_ready  = b_in_ready;
            m_out_valid = b_out_valid;
            m_out_sign  = b_out_sign;
            m_out_bcd   = {4'h0, b_out_bcd};
            m_ovf       = b_out_overflow;
        end else if (sel == 2) begin
            m_in_ready  = c_in_ready;
            m_out_valid = c_out_valid;
            m_out_sign  = c_out_sign;
            m_out_bcd   = c_out_bcd;
            m_ovf       = c_out_overflow;
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one word, waits for the result, checks it, optionally stalls, then drains.
    task automatic convert(input string tag, input int dut, input logic [15:0] data,
                           input logic sgn, input logic [19:0] exp_bcd, input logic exp_sign,
                           input logic exp_ovf, input int exp_lat, input int hold);
        int edges;
        sel       = dut;
        in_data   = data;
        in_signed = sgn;
        in_valid  = 1'b1;
        check({tag, " ready_before"}, 32'(m_in_ready), 32'd1);
        tick();
        in_valid  = 1'b0;
        in_data   = 16'hA5A5;
        in_signed = ~sgn;
        edges = 0;
        while (!m_out_valid && edges < 100) begin
            tick();
            edges++;
        end
        check({tag, " latency"}, 32'(edges), 32'(exp_lat));
        check({tag, " bcd"}, 32'(m_out_bcd), 32'(exp_bcd));
        check({tag, " sign"}, 32'(m_out_sign), 32'(exp_sign));
        check({tag, " ovf"}, 32'(m_ovf), 32'(exp_ovf));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h1234;
            tick();
            check({tag, " stall_valid"}, 32'(m_out_valid), 32'd1);
            check({tag, " stall_ready"}, 32'(m_in_ready), 32'd0);
            check({tag, " stall_bcd"}, 32'(m_out_bcd), 32'(exp_bcd));
            check({tag, " stall_sign"}, 32'(m_out_sign), 32'(exp_sign));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " drain_valid"}, 32'(m_out_valid), 32'd0);
        check({tag, " drain_ready"}, 32'(m_in_ready), 32'd1);
    endtask

    initial begin
        int first, second, edges;
        tick();
        tick();
        rst = 1'b0;
        check("rst in_ready", 32'(a_in_ready), 32'd1);
        check("rst out_valid", 32'(a_out_valid), 32'd0);
        check("rst out_sign", 32'(a_out_sign), 32'd0);
        check("rst out_bcd", 32'(a_out_bcd), 32'd0);
        check("rst out_ovf", 32'(a_out_overflow), 32'd0);

        convert("u_ffff",  0, 16'hFFFF, 1'b0, 20'h65535, 1'b0, 1'b0, 16, 0);
        convert("s_8000",  0, 16'h8000, 1'b1, 20'h32768, 1'b1, 1'b0, 16, 0);
        convert("s_ffff",  0, 16'hFFFF, 1'b1, 20'h00001, 1'b1, 1'b0, 16, 0);
        convert("u_8000",  0, 16'h8000, 1'b0, 20'h32768, 1'b0, 1'b0, 16, 0);
        convert("zero",    0, 16'h0000, 1'b1, 20'h00000, 1'b0, 1'b0, 16, 0);
        convert("stall",   0, 16'd4321, 1'b0, 20'h04321, 1'b0, 1'b0, 16, 10);
        convert("d4_12345", 1, 16'd12345, 1'b0, 20'h02345, 1'b0, 1'b1, 16, 0);
        convert("d4_9999", 1, 16'd9999, 1'b0, 20'h09999, 1'b0, 1'b0, 16, 0);
        convert("d4_neg1", 1, 16'hFFFF, 1'b1, 20'h00001, 1'b1, 1'b0, 16, 0);
        convert("bpc4_1000", 2, 16'd1000, 1'b0, 20'h01000, 1'b0, 1'b0, 4, 0);
        convert("bpc4_s",  2, 16'hFF85, 1'b1, 20'h00123, 1'b1, 1'b0, 4, 0);

        // Abort mid-conversion, then confirm the next word is unaffected.
        sel      = 0;
        in_data  = 16'd65000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort out_valid", 32'(a_out_valid), 32'd0);
        check("abort in_ready", 32'(a_in_ready), 32'd1);
        convert("after_rst", 0, 16'd42, 1'b0, 20'h00042, 1'b0, 1'b0, 16, 0);

        // Back-to-back words with both handshakes held high.
        sel       = 2;
        in_data   = 16'd1000;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        first  = -1;
        second = -1;
        edges  = 0;
        while (second < 0 && edges < 40) begin
            tick();
            edges++;
            if (c_out_valid) begin
                check("b2b bcd", 32'(c_out_bcd), 32'h01000);
                if (first < 0) first = edges;
                else           second = edges;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b first", 32'(first), 32'd5);
        check("b2b period", 32'(second - first), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
